// File: rtl/cpu_types_pkg.sv
// Shared types for the data cache: frame layout, address split, FSM states.
package cpu_types_pkg;
    typedef logic [31:0] word_t;

    localparam word_t DCACHE_CNT_ADDR = 32'h3100;
    localparam int    TAG_MAX         = 29;

    // Default geometry (8 sets); wider sets shrink the tag, stored zero-extended.
    typedef struct packed {
        logic [25:0] tag;
        logic [2:0]  idx;
        logic        blkoff;
        logic [1:0]  bytoff;
    } dcachef_t;

    typedef struct packed {
        logic               valid;
        logic               dirty;
        logic [TAG_MAX-1:0] tag;
        word_t [1:0]        data;
    } dcache_frame_t;

    typedef enum logic [3:0] {
        IDLE, WB0, WB1, LOAD0, LOAD1, FLUSH, FWB0, FWB1, CNT, DONE
    } dcache_state_t;
endpackage

// File: rtl/dcache_if.sv
// Datapath-side and memory-side signals of the data cache in one bundle.
interface dcache_if;
    import cpu_types_pkg::*;

    logic  dmemREN, dmemWEN, halt, dhit, flushed;
    word_t dmemaddr, dmemstore, dmemload;
    logic  dREN, dWEN, dwait;
    word_t daddr, dstore, dload;

    modport slave (
        input  dmemREN, dmemWEN, dmemaddr, dmemstore, halt, dwait, dload,
        output dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
    );
    modport master (
        output dmemREN, dmemWEN, dmemaddr, dmemstore, halt, dwait, dload,
        input  dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
    );
endinterface

// File: rtl/dcache.sv
// Two-way set-associative write-back data cache with halt-time flush.
// Optional hit counter written at flush end: define DCACHE_HITCNT_EN.
//   state | meaning
//   IDLE  | serve hits, detect misses and halt
//   WB0/1 | write back dirty victim words 0/1
//   LOAD0/1 | fetch requested block words 0/1
//   FLUSH | examine entry {set,way} of the flush walk
//   FWB0/1 | write back dirty flush entry words 0/1
//   CNT   | write hit counter to CNT_ADDR
//   DONE  | flush complete, terminal
module dcache
    import cpu_types_pkg::*;
#(
    parameter int    SETS     = 8,
    parameter word_t CNT_ADDR = DCACHE_CNT_ADDR
) (
    input logic      CLK,
    input logic      nRST,
    dcache_if.slave  bus
);
    localparam int IW = $clog2(SETS);
    localparam int TW = TAG_MAX - IW;

    dcache_frame_t      frames [SETS][2];
    logic [SETS-1:0]    lru;
    dcache_state_t      state, state_nx;
    logic [IW:0]        fcnt;

    logic [IW-1:0]      idx, fidx;
    logic               off, fway, vway, hit0, hit1, hit, req, done, miss_start;
    logic [TAG_MAX-1:0] rtag;
    logic [TW-1:0]      vtag, ftag;
    logic               vdirty, fdirty, dhit_c, flushed_c, ren, wen;
    word_t              addr_c, store_c, load_c, cnt_word;
    logic               unused_bytoff;

    assign idx    = bus.dmemaddr[3+IW-1:3];
    assign off    = bus.dmemaddr[2];
    assign rtag   = TAG_MAX'(bus.dmemaddr[31:3+IW]);
    assign unused_bytoff = ^bus.dmemaddr[1:0];
    assign req    = bus.dmemREN | bus.dmemWEN;
    assign hit0   = frames[idx][0].valid && (frames[idx][0].tag == rtag);
    assign hit1   = frames[idx][1].valid && (frames[idx][1].tag == rtag);
    assign hit    = hit0 | hit1;
    assign vway   = lru[idx];
    assign vtag   = frames[idx][vway].tag[TW-1:0];
    assign vdirty = frames[idx][vway].valid && frames[idx][vway].dirty;
    assign fidx   = fcnt[IW:1];
    assign fway   = fcnt[0];
    assign ftag   = frames[fidx][fway].tag[TW-1:0];
    assign fdirty = frames[fidx][fway].valid && frames[fidx][fway].dirty;
    assign done   = !bus.dwait;

`ifdef DCACHE_HITCNT_EN
    localparam dcache_state_t FLUSH_END = CNT;
    logic signed [31:0] hitcnt;
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)           hitcnt <= '0;
        else if (dhit_c)     hitcnt <= hitcnt + 32'sd1;
        else if (miss_start) hitcnt <= hitcnt - 32'sd1;
    end
    assign cnt_word = hitcnt;
`else
    localparam dcache_state_t FLUSH_END = DONE;
    logic unused_cnt;
    assign unused_cnt = miss_start;
    assign cnt_word   = '0;
`endif

    always_comb begin
        state_nx   = state;
        dhit_c     = 1'b0;
        flushed_c  = 1'b0;
        miss_start = 1'b0;
        ren        = 1'b0;
        wen        = 1'b0;
        addr_c     = '0;
        store_c    = '0;
        load_c     = '0;
        case (state)
            IDLE: begin
                if (bus.halt) begin
                    state_nx = FLUSH;
                end else if (req && hit) begin
                    dhit_c = 1'b1;
                    load_c = hit1 ? frames[idx][1].data[off] : frames[idx][0].data[off];
                end else if (req) begin
                    miss_start = 1'b1;
                    state_nx   = vdirty ? WB0 : LOAD0;
                end
            end
            WB0, WB1: begin
                wen     = 1'b1;
                addr_c  = {vtag, idx, (state == WB1), 2'b00};
                store_c = frames[idx][vway].data[state == WB1];
                if (done) state_nx = (state == WB0) ? WB1 : LOAD0;
            end
            LOAD0, LOAD1: begin
                ren    = 1'b1;
                addr_c = {rtag[TW-1:0], idx, (state == LOAD1), 2'b00};
                if (done) state_nx = (state == LOAD0) ? LOAD1 : IDLE;
            end
            FLUSH: begin
                if (fdirty)     state_nx = FWB0;
                else if (&fcnt) state_nx = FLUSH_END;
            end
            FWB0, FWB1: begin
                wen     = 1'b1;
                addr_c  = {ftag, fidx, (state == FWB1), 2'b00};
                store_c = frames[fidx][fway].data[state == FWB1];
                if (done) begin
                    if (state == FWB0) state_nx = FWB1;
                    else               state_nx = (&fcnt) ? FLUSH_END : FLUSH;
                end
            end
            CNT: begin
                wen     = 1'b1;
                addr_c  = CNT_ADDR;
                store_c = cnt_word;
                if (done) state_nx = DONE;
            end
            DONE:    flushed_c = 1'b1;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            lru   <= '0;
            fcnt  <= '0;
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < 2; w++)
                    frames[s][w] <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (dhit_c) begin
                    if (bus.dmemWEN) begin
                        frames[idx][hit1].data[off] <= bus.dmemstore;
                        frames[idx][hit1].dirty     <= 1'b1;
                    end
                    lru[idx] <= ~hit1;
                end
                LOAD0: if (done) frames[idx][vway].data[0] <= bus.dload;
                LOAD1: if (done) begin
                    frames[idx][vway].data[1] <= bus.dload;
                    frames[idx][vway].tag     <= rtag;
                    frames[idx][vway].valid   <= 1'b1;
                    frames[idx][vway].dirty   <= 1'b0;
                end
                FLUSH: if (!fdirty) fcnt <= fcnt + 1'b1;
                FWB1: if (done) begin
                    frames[fidx][fway].dirty <= 1'b0;
                    fcnt <= fcnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.dhit     = dhit_c;
    assign bus.dmemload = load_c;
    assign bus.flushed  = flushed_c;
    assign bus.dREN     = ren;
    assign bus.dWEN     = wen;
    assign bus.daddr    = addr_c;
    assign bus.dstore   = store_c;
endmodule
